// File: rtl/hex_item_scroller.sv
// Item-code letter decoder that scrolls a purchased letter across NUM_DIGITS seven-segment digits.
// Optional blink on the coupon input is compiled in with the HEX_ITEM_BLINK_EN macro.
module hex_item_scroller #(
  parameter int NUM_DIGITS = 6,
  parameter int TICK_DIV   = 25_000_000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [2:0]                U,
  input  logic                      P,
  input  logic                      C,
  output logic [7*NUM_DIGITS-1:0]   hex_out,
  output logic                      busy
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int PW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
  localparam logic [PW-1:0] POS_LAST  = PW'(NUM_DIGITS - 1);
  localparam logic [6:0]    BLANK     = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCROLL = 2'd1,
    HOLD   = 2'd2
  } state_t;

  function automatic logic [6:0] decode_letter(input logic [2:0] code);
    logic [6:0] seg;
    case (code)
      3'b000:  seg = 7'b0111000;
      3'b001:  seg = 7'b1000110;
      3'b010:  seg = 7'b1100111;
      3'b100:  seg = 7'b1011100;
      3'b101:  seg = 7'b1100011;
      3'b111:  seg = 7'b0111010;
      default: seg = 7'b0000000;
    endcase
    return seg;
  endfunction

  state_t                    state_q, state_d;
  logic [PW-1:0]             pos_q, pos_d;
  logic [CW-1:0]             tick_cnt_q, tick_cnt_d;
  logic [2:0]                code_q, code_d;
  logic [7*NUM_DIGITS-1:0]   hex_q, hex_d;
  logic                      busy_q, busy_d;
  logic                      tick_s;
  logic                      accept_s;
  logic                      blank_all_s;

`ifdef HEX_ITEM_BLINK_EN
  logic blink_q, blink_d;

  // Blink phase flips on every tick regardless of state or purchase.
  always_comb begin
    blink_d     = blink_q;
    blank_all_s = C && blink_q;
    if (tick_s) begin
      blink_d = ~blink_q;
    end else begin
      blink_d = blink_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      blink_q <= 1'b0;
    end else begin
      blink_q <= blink_d;
    end
  end
`else
  logic unused_c;
  assign unused_c    = C;
  assign blank_all_s = 1'b0;
`endif

  // Next state, scroll position, tick divider and latched code.
  always_comb begin
    state_d    = state_q;
    pos_d      = pos_q;
    code_d     = code_q;
    tick_s     = (tick_cnt_q == TICK_LAST);
    accept_s   = (state_q == IDLE) && P;
    if (accept_s || tick_s) begin
      tick_cnt_d = {CW{1'b0}};
    end else begin
      tick_cnt_d = tick_cnt_q + CW'(1);
    end
    case (state_q)
      IDLE: begin
        if (P) begin
          state_d = SCROLL;
          pos_d   = {PW{1'b0}};
          code_d  = U;
        end else begin
          state_d = IDLE;
        end
      end
      SCROLL: begin
        if (tick_s) begin
          if (pos_q == POS_LAST) begin
            state_d = HOLD;
          end else begin
            pos_d = pos_q + PW'(1);
          end
        end else begin
          state_d = SCROLL;
        end
      end
      HOLD: begin
        if (tick_s) begin
          state_d = IDLE;
          pos_d   = {PW{1'b0}};
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = IDLE;
        pos_d   = {PW{1'b0}};
      end
    endcase
  end

  // Display content; the blink override wins over everything else.
  always_comb begin
    hex_d  = {(7*NUM_DIGITS){1'b1}};
    busy_d = (state_q != IDLE);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      case (state_q)
        IDLE:    hex_d[7*i +: 7] = (i == 0) ? decode_letter(U) : BLANK;
        SCROLL:  hex_d[7*i +: 7] = (pos_q == PW'(i)) ? decode_letter(code_q) : BLANK;
        HOLD:    hex_d[7*i +: 7] = decode_letter(code_q);
        default: hex_d[7*i +: 7] = BLANK;
      endcase
      if (blank_all_s) begin
        hex_d[7*i +: 7] = BLANK;
      end else begin
        hex_d[7*i +: 7] = hex_d[7*i +: 7];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      pos_q      <= {PW{1'b0}};
      tick_cnt_q <= {CW{1'b0}};
      code_q     <= 3'b000;
      hex_q      <= {(7*NUM_DIGITS){1'b1}};
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pos_q      <= pos_d;
      tick_cnt_q <= tick_cnt_d;
      code_q     <= code_d;
      hex_q      <= hex_d;
      busy_q     <= busy_d;
    end
  end

  assign hex_out = hex_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_hex_item_scroller.sv
// Self-checking bench for hex_item_scroller (NUM_DIGITS=6, TICK_DIV=4): directed steps then random
// stimulus, all compared against a cycle-count reference model of the scroll/hold/blink behaviour.
module tb_hex_item_scroller;
  localparam int N = 6;
  localparam int T = 4;

  logic          clk = 1'b0;
  logic          reset, P, C;
  logic [2:0]    U;
  logic [7*N-1:0] hex_out;
  logic          busy;

  int total = 0;
  int bad   = 0;

  logic [6:0] lut [8];
  int m_busy, m_e, m_c, m_blink;
  logic [2:0] m_code;

  hex_item_scroller #(.NUM_DIGITS(N), .TICK_DIV(T)) dut (
    .clk(clk), .reset(reset), .U(U), .P(P), .C(C), .hex_out(hex_out), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: apply inputs, predict from the model, advance, compare.
  task automatic step(input logic r, input logic [2:0] u, input logic p, input logic c);
    logic [7*N-1:0] eh;
    logic eb;
    bit tk;
    reset = r; U = u; P = p; C = c;
    eh = '1;
    eb = 1'b0;
    if (!r) begin
      eb = (m_busy != 0);
      if (m_busy == 0) eh[6:0] = lut[u];
      else if (m_e < N*T) eh[7*(m_e/T) +: 7] = lut[m_code];
      else for (int i = 0; i < N; i++) eh[7*i +: 7] = lut[m_code];
`ifdef HEX_ITEM_BLINK_EN
      if (c && m_blink != 0) eh = '1;
`endif
    end
    if (r) begin
      m_busy = 0; m_e = 0; m_c = 0; m_blink = 0; m_code = 3'b000;
    end else begin
      tk = ((m_c % T) == T-1);
      if (tk) m_blink = 1 - m_blink;
      if (m_busy == 0 && p) begin
        m_busy = 1; m_e = 0; m_c = 0; m_code = u;
      end else begin
        m_c++;
        if (m_busy != 0) begin
          m_e++;
          if (m_e == (N+1)*T) m_busy = 0;
        end
      end
    end
    @(posedge clk);
    #1;
    chk("hex_out", 64'(hex_out), 64'(eh));
    chk("busy", 64'(busy), 64'(eb));
  endtask

  initial begin
    int cnt;
    logic [2:0] ru;
    logic rc;
    lut = '{7'b0111000, 7'b1000110, 7'b1100111, 7'b0000000,
            7'b1011100, 7'b1100011, 7'b0000000, 7'b0111010};
    m_busy = 0; m_e = 0; m_c = 0; m_blink = 0; m_code = 3'b000;
    reset = 1'b1; U = 3'b000; P = 1'b0; C = 1'b0;

    step(1'b1, 3'b000, 1'b0, 1'b0);
    chk("reset_hex", 64'(hex_out), 64'(42'h3FF_FFFF_FFFF));
    chk("reset_busy", 64'(busy), 64'd0);
    step(1'b0, 3'b001, 1'b0, 1'b0);
    chk("idle_J", 64'(hex_out), 64'({35'h7_FFFF_FFFF, 7'b1000110}));
    step(1'b0, 3'b011, 1'b0, 1'b0);
    chk("invalid_011", 64'(hex_out[6:0]), 64'(7'b0000000));
    step(1'b0, 3'b110, 1'b0, 1'b0);
    chk("invalid_110", 64'(hex_out[6:0]), 64'(7'b0000000));

    // Full scroll of B, with a second purchase and new U mid-scroll that must be ignored.
    step(1'b0, 3'b100, 1'b1, 1'b0);
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (k == 9) step(1'b0, 3'b000, 1'b1, 1'b0);
      else step(1'b0, 3'b000, 1'b0, 1'b0);
      if (k == 0) chk("first_B", 64'(hex_out[6:0]), 64'(7'b1011100));
      if (busy) cnt++;
    end
    chk("busy_len", 64'(cnt), 64'd28);

    // Reset on the third SCROLL tick.
    step(1'b0, 3'b100, 1'b1, 1'b0);
    for (int k = 0; k < 11; k++) step(1'b0, 3'b100, 1'b0, 1'b0);
    step(1'b1, 3'b100, 1'b0, 1'b0);
    chk("mid_reset_hex", 64'(hex_out), 64'(42'h3FF_FFFF_FFFF));
    chk("mid_reset_busy", 64'(busy), 64'd0);
    step(1'b0, 3'b101, 1'b0, 1'b0);
    chk("after_reset_live", 64'(hex_out[6:0]), 64'(7'b1100011));

    // Coupon in IDLE showing K (blinks only when compiled in).
    for (int k = 0; k < 16; k++) step(1'b0, 3'b111, 1'b0, 1'b1);

    // P held high: re-accepted right after HOLD ends.
    for (int k = 0; k < 70; k++) step(1'b0, 3'b010, 1'b1, 1'b0);

    ru = 3'b000;
    rc = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 3) == 0) ru = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) rc = ~rc;
      step(($urandom_range(0, 199) == 0), ru, ($urandom_range(0, 7) == 0), rc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
